// File: rtl/iob_eth_mii_rx_framer.sv
// MII receive framer: strips preamble/SFD, packs nibbles into bytes with
// sof/eof markers, flags odd/short/long frames and keeps saturating counts.
module iob_eth_mii_rx_framer #(
    parameter int MIN_FRAME_LEN = 64,
    parameter int MAX_FRAME_LEN = 1518,
    parameter int LEN_W         = 11
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [3:0]       mii_rxd_i,
    input  logic             mii_rx_dv_i,
    output logic [7:0]       data_o,
    output logic             valid_o,
    output logic             sof_o,
    output logic             eof_o,
    output logic             err_o,
    output logic [LEN_W-1:0] len_o,
    output logic [15:0]      frames_ok_o,
    output logic [15:0]      frames_err_o
);

    typedef enum logic [1:0] {
        IDLE,
        PREAMBLE,
        DATA,
        DROP
    } state_t;

    localparam logic [LEN_W-1:0] MIN_LEN = LEN_W'(MIN_FRAME_LEN);
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_FRAME_LEN);

    state_t           state_q, state_d;
    logic             lock_q, lock_d;
    logic             low_pend_q, low_pend_d;
    logic [3:0]       low_nib_q, low_nib_d;
    logic             hold_vld_q, hold_vld_d;
    logic             hold_first_q, hold_first_d;
    logic [7:0]       hold_q, hold_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             sof_q, sof_d;
    logic             eof_q, eof_d;
    logic             err_q, err_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [15:0]      frames_ok_q, frames_ok_d;
    logic [15:0]      frames_err_q, frames_err_d;
    logic             zero_frame;
    logic             ok_inc;
    logic             err_inc;

    // Frame parser: the hold register delays each byte by one so that the
    // last byte can carry eof once dv falls.
    always_comb begin
        state_d      = state_q;
        lock_d       = lock_q & mii_rx_dv_i;
        low_pend_d   = low_pend_q;
        low_nib_d    = low_nib_q;
        hold_vld_d   = hold_vld_q;
        hold_first_d = hold_first_q;
        hold_d       = hold_q;
        cnt_d        = cnt_q;
        data_d       = data_q;
        valid_d      = 1'b0;
        sof_d        = 1'b0;
        eof_d        = 1'b0;
        err_d        = 1'b0;
        len_d        = '0;
        zero_frame   = 1'b0;

        case (state_q)
            IDLE: begin
                low_pend_d = 1'b0;
                hold_vld_d = 1'b0;
                cnt_d      = '0;
                if (mii_rx_dv_i) begin
                    // After reset the line is ignored until dv has been seen low.
                    if (lock_q || (mii_rxd_i != 4'h5)) begin
                        state_d = DROP;
                    end else begin
                        state_d = PREAMBLE;
                    end
                end
            end

            PREAMBLE: begin
                if (!mii_rx_dv_i) begin
                    state_d = IDLE;
                end else if (mii_rxd_i == 4'hD) begin
                    state_d    = DATA;
                    low_pend_d = 1'b0;
                    hold_vld_d = 1'b0;
                    cnt_d      = '0;
                end else if (mii_rxd_i != 4'h5) begin
                    state_d = DROP;
                end
            end

            DATA: begin
                if (!mii_rx_dv_i) begin
                    state_d    = IDLE;
                    low_pend_d = 1'b0;
                    hold_vld_d = 1'b0;
                    if (hold_vld_q) begin
                        data_d  = hold_q;
                        valid_d = 1'b1;
                        sof_d   = hold_first_q;
                        eof_d   = 1'b1;
                        err_d   = low_pend_q || (cnt_q < MIN_LEN);
                        len_d   = cnt_q;
                    end else begin
                        zero_frame = 1'b1;
                    end
                end else if (!low_pend_q) begin
                    low_nib_d  = mii_rxd_i;
                    low_pend_d = 1'b1;
                end else begin
                    low_pend_d = 1'b0;
                    if (cnt_q == MAX_LEN) begin
                        // Overlength: close the frame on the held byte, discard the new one.
                        data_d     = hold_q;
                        valid_d    = 1'b1;
                        sof_d      = hold_first_q;
                        eof_d      = 1'b1;
                        err_d      = 1'b1;
                        len_d      = MAX_LEN;
                        hold_vld_d = 1'b0;
                        state_d    = DROP;
                    end else begin
                        if (hold_vld_q) begin
                            data_d  = hold_q;
                            valid_d = 1'b1;
                            sof_d   = hold_first_q;
                        end
                        hold_d       = {mii_rxd_i, low_nib_q};
                        hold_vld_d   = 1'b1;
                        hold_first_d = !hold_vld_q;
                        cnt_d        = cnt_q + LEN_W'(1);
                    end
                end
            end

            DROP: begin
                if (!mii_rx_dv_i) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = DROP;
            end
        endcase
    end

    // Saturating frame statistics, stepped on the edge that drives each eof beat.
    always_comb begin
        ok_inc       = eof_d & ~err_d;
        err_inc      = (eof_d & err_d) | zero_frame;
        frames_ok_d  = frames_ok_q;
        frames_err_d = frames_err_q;
        if (ok_inc && (frames_ok_q != 16'hFFFF)) begin
            frames_ok_d = frames_ok_q + 16'd1;
        end
        if (err_inc && (frames_err_q != 16'hFFFF)) begin
            frames_err_d = frames_err_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            lock_q       <= 1'b1;
            low_pend_q   <= 1'b0;
            low_nib_q    <= 4'h0;
            hold_vld_q   <= 1'b0;
            hold_first_q <= 1'b0;
            hold_q       <= 8'h00;
            cnt_q        <= '0;
            data_q       <= 8'h00;
            valid_q      <= 1'b0;
            sof_q        <= 1'b0;
            eof_q        <= 1'b0;
            err_q        <= 1'b0;
            len_q        <= '0;
            frames_ok_q  <= 16'h0000;
            frames_err_q <= 16'h0000;
        end else begin
            state_q      <= state_d;
            lock_q       <= lock_d;
            low_pend_q   <= low_pend_d;
            low_nib_q    <= low_nib_d;
            hold_vld_q   <= hold_vld_d;
            hold_first_q <= hold_first_d;
            hold_q       <= hold_d;
            cnt_q        <= cnt_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            sof_q        <= sof_d;
            eof_q        <= eof_d;
            err_q        <= err_d;
            len_q        <= len_d;
            frames_ok_q  <= frames_ok_d;
            frames_err_q <= frames_err_d;
        end
    end

    assign data_o       = data_q;
    assign valid_o      = valid_q;
    assign sof_o        = sof_q;
    assign eof_o        = eof_q;
    assign err_o        = err_q;
    assign len_o        = len_q;
    assign frames_ok_o  = frames_ok_q;
    assign frames_err_o = frames_err_q;

endmodule

// File: tb/tb_iob_eth_mii_rx_framer.sv
// Directed self-checking bench for the MII receive framer.
module tb_iob_eth_mii_rx_framer;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [3:0]  mii_rxd_i;
    logic        mii_rx_dv_i;
    logic [7:0]  data_o;
    logic        valid_o;
    logic        sof_o;
    logic        eof_o;
    logic        err_o;
    logic [10:0] len_o;
    logic [15:0] frames_ok_o;
    logic [15:0] frames_err_o;

    int checks = 0;
    int passed = 0;
    int cyc = 0;
    int quiet_viol = 0;

    typedef struct {
        logic [7:0]  data;
        logic        sof;
        logic        eof;
        logic        err;
        logic [10:0] len;
        int          cyc;
    } beat_t;

    beat_t beats[$];

    iob_eth_mii_rx_framer #(
        .MIN_FRAME_LEN(64),
        .MAX_FRAME_LEN(1518),
        .LEN_W(11)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .mii_rxd_i(mii_rxd_i),
        .mii_rx_dv_i(mii_rx_dv_i),
        .data_o(data_o),
        .valid_o(valid_o),
        .sof_o(sof_o),
        .eof_o(eof_o),
        .err_o(err_o),
        .len_o(len_o),
        .frames_ok_o(frames_ok_o),
        .frames_err_o(frames_err_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Beat logger; markers seen without valid_o are counted as violations.
    always @(negedge clk_i) begin
        if (valid_o === 1'b1) begin
            beats.push_back('{data_o, sof_o, eof_o, err_o, len_o, cyc});
        end else if ((sof_o !== 1'b0) || (eof_o !== 1'b0) || (err_o !== 1'b0) || (len_o !== 11'd0)) begin
            quiet_viol++;
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL timeout: got running expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic drive(input logic v, input logic [3:0] n);
        @(negedge clk_i);
        mii_rx_dv_i = v;
        mii_rxd_i   = n;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 4'h0);
    endtask

    task automatic send_preamble();
        for (int i = 0; i < 15; i++) drive(1'b1, 4'h5);
        drive(1'b1, 4'hD);
    endtask

    task automatic send_bytes(input int n, input int start);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            b = 8'(start + i);
            drive(1'b1, b[3:0]);
            drive(1'b1, b[7:4]);
        end
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i       = 1'b1;
        mii_rx_dv_i = 1'b0;
        mii_rxd_i   = 4'h0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        idle(2);
    endtask

    task automatic test_reset();
        rst_i       = 1'b1;
        mii_rx_dv_i = 1'b0;
        mii_rxd_i   = 4'h0;
        repeat (3) @(negedge clk_i);
        checks++; if (valid_o !== 1'b0) $display("[TB] FAIL reset_valid: got %0b expected 0", valid_o); else passed++;
        checks++; if (data_o !== 8'h00) $display("[TB] FAIL reset_data: got %0h expected 0", data_o); else passed++;
        checks++; if ({sof_o, eof_o, err_o} !== 3'b000) $display("[TB] FAIL reset_markers: got %b expected 000", {sof_o, eof_o, err_o}); else passed++;
        checks++; if (len_o !== 11'd0) $display("[TB] FAIL reset_len: got %0d expected 0", len_o); else passed++;
        checks++; if (frames_ok_o !== 16'd0) $display("[TB] FAIL reset_ok: got %0d expected 0", frames_ok_o); else passed++;
        checks++; if (frames_err_o !== 16'd0) $display("[TB] FAIL reset_err: got %0d expected 0", frames_err_o); else passed++;
        rst_i = 1'b0;
        idle(3);
    endtask

    task automatic test_good_frame();
        int c_first, c_last, n, data_err, sof_n, eof_n;
        beats.delete();
        quiet_viol = 0;
        send_preamble();
        send_bytes(2, 0);
        c_first = cyc;
        send_bytes(62, 2);
        drive(1'b0, 4'h0);
        c_last = cyc;
        idle(4);
        n = beats.size();
        data_err = 0; sof_n = 0; eof_n = 0;
        for (int i = 0; i < n; i++) begin
            if (beats[i].data !== 8'(i)) data_err++;
            if (beats[i].sof) sof_n++;
            if (beats[i].eof) eof_n++;
        end
        checks++; if (n != 64) $display("[TB] FAIL good_count: got %0d expected 64", n); else passed++;
        checks++; if (data_err != 0) $display("[TB] FAIL good_data: got %0d bad bytes expected 0", data_err); else passed++;
        checks++; if (sof_n != 1 || n == 0 || beats[0].sof !== 1'b1) $display("[TB] FAIL good_sof: got %0d sof beats expected 1 on first", sof_n); else passed++;
        checks++; if (eof_n != 1 || n == 0 || beats[n-1].eof !== 1'b1) $display("[TB] FAIL good_eof: got %0d eof beats expected 1 on last", eof_n); else passed++;
        checks++; if (n == 0 || beats[n-1].len !== 11'd64 || beats[n-1].err !== 1'b0) $display("[TB] FAIL good_len_err: got len %0d err %0b expected 64/0", (n > 0) ? beats[n-1].len : 11'd0, (n > 0) ? beats[n-1].err : 1'bx); else passed++;
        checks++; if (n == 0 || beats[0].cyc != c_first + 1) $display("[TB] FAIL good_first_latency: got cycle %0d expected %0d", (n > 0) ? beats[0].cyc : -1, c_first + 1); else passed++;
        checks++; if (n == 0 || beats[n-1].cyc != c_last + 1) $display("[TB] FAIL good_eof_latency: got cycle %0d expected %0d", (n > 0) ? beats[n-1].cyc : -1, c_last + 1); else passed++;
        checks++; if (frames_ok_o !== 16'd1) $display("[TB] FAIL good_ok_cnt: got %0d expected 1", frames_ok_o); else passed++;
        checks++; if (frames_err_o !== 16'd0) $display("[TB] FAIL good_err_cnt: got %0d expected 0", frames_err_o); else passed++;
        checks++; if (quiet_viol != 0) $display("[TB] FAIL good_quiet: got %0d violations expected 0", quiet_viol); else passed++;
    endtask

    task automatic test_odd_short();
        int n, data_err;
        beats.delete();
        send_preamble();
        send_bytes(10, 8'hA0);
        drive(1'b1, 4'h7);
        idle(4);
        n = beats.size();
        data_err = 0;
        for (int i = 0; i < n; i++) if (beats[i].data !== 8'(8'hA0 + i)) data_err++;
        checks++; if (n != 10) $display("[TB] FAIL odd_count: got %0d expected 10", n); else passed++;
        checks++; if (data_err != 0) $display("[TB] FAIL odd_data: got %0d bad bytes expected 0", data_err); else passed++;
        checks++; if (n == 0 || beats[n-1].eof !== 1'b1 || beats[n-1].err !== 1'b1 || beats[n-1].len !== 11'd10) $display("[TB] FAIL odd_eof: got eof/err/len %0b/%0b/%0d expected 1/1/10", (n > 0) ? beats[n-1].eof : 1'bx, (n > 0) ? beats[n-1].err : 1'bx, (n > 0) ? beats[n-1].len : 11'd0); else passed++;
        checks++; if (frames_err_o !== 16'd1 || frames_ok_o !== 16'd1) $display("[TB] FAIL odd_cnt: got ok %0d err %0d expected 1/1", frames_ok_o, frames_err_o); else passed++;
    endtask

    task automatic test_short_boundary();
        int n;
        beats.delete();
        send_preamble();
        send_bytes(63, 8'h20);
        idle(4);
        n = beats.size();
        checks++; if (n != 63) $display("[TB] FAIL short63_count: got %0d expected 63", n); else passed++;
        checks++; if (n == 0 || beats[n-1].err !== 1'b1 || beats[n-1].len !== 11'd63 || beats[n-1].data !== 8'h5E) $display("[TB] FAIL short63_eof: got err %0b len %0d data %0h expected 1/63/5e", (n > 0) ? beats[n-1].err : 1'bx, (n > 0) ? beats[n-1].len : 11'd0, (n > 0) ? beats[n-1].data : 8'h00); else passed++;
        checks++; if (frames_err_o !== 16'd2 || frames_ok_o !== 16'd1) $display("[TB] FAIL short63_cnt: got ok %0d err %0d expected 1/2", frames_ok_o, frames_err_o); else passed++;
    endtask

    task automatic test_bad_preamble();
        beats.delete();
        quiet_viol = 0;
        drive(1'b1, 4'h5);
        drive(1'b1, 4'h5);
        drive(1'b1, 4'h3);
        send_bytes(70, 0);
        idle(4);
        checks++; if (beats.size() != 0) $display("[TB] FAIL badpre_count: got %0d beats expected 0", beats.size()); else passed++;
        checks++; if (frames_err_o !== 16'd2 || frames_ok_o !== 16'd1) $display("[TB] FAIL badpre_cnt: got ok %0d err %0d expected 1/2", frames_ok_o, frames_err_o); else passed++;
        checks++; if (quiet_viol != 0) $display("[TB] FAIL badpre_quiet: got %0d violations expected 0", quiet_viol); else passed++;
    endtask

    task automatic test_overlength();
        int n, data_err, sof_n, eof_n;
        beats.delete();
        send_preamble();
        send_bytes(1600, 0);
        idle(4);
        n = beats.size();
        data_err = 0; sof_n = 0; eof_n = 0;
        for (int i = 0; i < n; i++) begin
            if (beats[i].data !== 8'(i)) data_err++;
            if (beats[i].sof) sof_n++;
            if (beats[i].eof) eof_n++;
        end
        checks++; if (n != 1518) $display("[TB] FAIL long_count: got %0d expected 1518", n); else passed++;
        checks++; if (data_err != 0 || sof_n != 1) $display("[TB] FAIL long_data: got %0d bad bytes %0d sof expected 0/1", data_err, sof_n); else passed++;
        checks++; if (eof_n != 1 || n == 0 || beats[n-1].eof !== 1'b1 || beats[n-1].err !== 1'b1 || beats[n-1].len !== 11'd1518) $display("[TB] FAIL long_eof: got %0d eofs len %0d expected 1 eof err len 1518", eof_n, (n > 0) ? beats[n-1].len : 11'd0); else passed++;
        checks++; if (frames_err_o !== 16'd3 || frames_ok_o !== 16'd1) $display("[TB] FAIL long_cnt: got ok %0d err %0d expected 1/3", frames_ok_o, frames_err_o); else passed++;
    endtask

    task automatic test_reset_mid_frame();
        int n, data_err;
        beats.delete();
        send_preamble();
        send_bytes(20, 0);
        @(negedge clk_i);
        rst_i       = 1'b1;
        mii_rx_dv_i = 1'b1;
        mii_rxd_i   = 4'h4;
        @(negedge clk_i);
        rst_i = 1'b0;
        checks++; if (valid_o !== 1'b0 || data_o !== 8'h00) $display("[TB] FAIL rstmid_out: got valid %0b data %0h expected 0/0", valid_o, data_o); else passed++;
        checks++; if (frames_ok_o !== 16'd0 || frames_err_o !== 16'd0) $display("[TB] FAIL rstmid_cnt: got ok %0d err %0d expected 0/0", frames_ok_o, frames_err_o); else passed++;
        beats.delete();
        quiet_viol = 0;
        send_preamble();
        send_bytes(44, 8'h14);
        idle(4);
        checks++; if (beats.size() != 0) $display("[TB] FAIL rstmid_drop: got %0d beats expected 0", beats.size()); else passed++;
        send_preamble();
        send_bytes(64, 8'h40);
        idle(4);
        n = beats.size();
        data_err = 0;
        for (int i = 0; i < n; i++) if (beats[i].data !== 8'(8'h40 + i)) data_err++;
        checks++; if (n != 64 || data_err != 0) $display("[TB] FAIL rstmid_next: got %0d beats %0d bad expected 64/0", n, data_err); else passed++;
        checks++; if (n == 0 || beats[n-1].err !== 1'b0 || beats[n-1].len !== 11'd64) $display("[TB] FAIL rstmid_eof: got len %0d expected 64 no err", (n > 0) ? beats[n-1].len : 11'd0); else passed++;
        checks++; if (frames_ok_o !== 16'd1 || frames_err_o !== 16'd0) $display("[TB] FAIL rstmid_final_cnt: got ok %0d err %0d expected 1/0", frames_ok_o, frames_err_o); else passed++;
        checks++; if (quiet_viol != 0) $display("[TB] FAIL rstmid_quiet: got %0d violations expected 0", quiet_viol); else passed++;
    endtask

    task automatic test_back_to_back();
        int n, data_err, sof_n, eof_n;
        logic [7:0] exp_b;
        do_reset();
        beats.delete();
        send_preamble();
        send_bytes(64, 8'h10);
        drive(1'b0, 4'h0);
        send_preamble();
        send_bytes(64, 8'h80);
        idle(4);
        n = beats.size();
        data_err = 0; sof_n = 0; eof_n = 0;
        for (int i = 0; i < n; i++) begin
            exp_b = (i < 64) ? 8'(8'h10 + i) : 8'(8'h80 + i - 64);
            if (beats[i].data !== exp_b) data_err++;
            if (beats[i].sof) sof_n++;
            if (beats[i].eof) eof_n++;
        end
        checks++; if (n != 128 || data_err != 0) $display("[TB] FAIL b2b_data: got %0d beats %0d bad expected 128/0", n, data_err); else passed++;
        checks++; if (n != 128 || sof_n != 2 || eof_n != 2 || beats[64].sof !== 1'b1 || beats[63].eof !== 1'b1 || beats[127].eof !== 1'b1) $display("[TB] FAIL b2b_markers: got %0d sof %0d eof expected 2/2", sof_n, eof_n); else passed++;
        checks++; if (n != 128 || beats[63].err !== 1'b0 || beats[127].err !== 1'b0 || beats[63].len !== 11'd64 || beats[127].len !== 11'd64) $display("[TB] FAIL b2b_len_err: got %0d beats expected two len 64 no err", n); else passed++;
        checks++; if (frames_ok_o !== 16'd2 || frames_err_o !== 16'd0) $display("[TB] FAIL b2b_cnt: got ok %0d err %0d expected 2/0", frames_ok_o, frames_err_o); else passed++;
    endtask

    task automatic test_one_byte();
        int n;
        beats.delete();
        send_preamble();
        send_bytes(1, 8'h5A);
        idle(4);
        n = beats.size();
        checks++; if (n != 1 || beats[0].data !== 8'h5A || beats[0].sof !== 1'b1 || beats[0].eof !== 1'b1) $display("[TB] FAIL one_byte_beat: got %0d beats expected 1 with data 5a sof eof", n); else passed++;
        checks++; if (n != 1 || beats[0].err !== 1'b1 || beats[0].len !== 11'd1) $display("[TB] FAIL one_byte_len: got %0d beats expected err len 1", n); else passed++;
        checks++; if (frames_ok_o !== 16'd2 || frames_err_o !== 16'd1) $display("[TB] FAIL one_byte_cnt: got ok %0d err %0d expected 2/1", frames_ok_o, frames_err_o); else passed++;
    endtask

    task automatic test_saturation();
        beats.delete();
        drive(1'b1, 4'h5);
        drive(1'b1, 4'hD);
        idle(3);
        checks++; if (beats.size() != 0 || frames_err_o !== 16'd2) $display("[TB] FAIL zero_frame: got %0d beats err %0d expected 0/2", beats.size(), frames_err_o); else passed++;
        // Preload the error counter near its ceiling rather than replaying 65k frames.
        @(negedge clk_i);
        force dut.frames_err_d = 16'hFFFD;
        @(negedge clk_i);
        release dut.frames_err_d;
        idle(2);
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 4'h5);
            drive(1'b1, 4'hD);
            drive(1'b0, 4'h0);
        end
        idle(2);
        checks++; if (frames_err_o !== 16'hFFFF) $display("[TB] FAIL sat_err_reach: got %0h expected ffff", frames_err_o); else passed++;
        drive(1'b1, 4'h5);
        drive(1'b1, 4'hD);
        idle(3);
        checks++; if (frames_err_o !== 16'hFFFF) $display("[TB] FAIL sat_err_hold: got %0h expected ffff", frames_err_o); else passed++;
        @(negedge clk_i);
        force dut.frames_ok_d = 16'hFFFE;
        @(negedge clk_i);
        release dut.frames_ok_d;
        idle(2);
        for (int i = 0; i < 2; i++) begin
            send_preamble();
            send_bytes(64, 0);
            drive(1'b0, 4'h0);
        end
        idle(3);
        checks++; if (frames_ok_o !== 16'hFFFF) $display("[TB] FAIL sat_ok_hold: got %0h expected ffff", frames_ok_o); else passed++;
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_odd_short();
        test_short_boundary();
        test_bad_preamble();
        test_overlength();
        test_reset_mid_frame();
        test_back_to_back();
        test_one_byte();
        test_saturation();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
